// File: rtl/adc_scan_avg.sv
// Multi-channel scanner for the MAX 10 modular ADC: issues one command per sample,
// averages 2^AVG_LOG2 samples per channel and raises per-channel threshold flags.
module adc_scan_avg #(
  parameter int NUM_CH   = 3,
  parameter int CH_BASE  = 1,
  parameter int CH_W     = 5,
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 1023,
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              SYS_CLK,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic [DATA_W-1:0] threshold,
  output logic              cmd_valid,
  output logic [CH_W-1:0]   cmd_channel,
  output logic              cmd_sop,
  output logic              cmd_eop,
  input  logic              cmd_ready,
  input  logic              rsp_valid,
  input  logic [CH_W-1:0]   rsp_channel,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              result_valid,
  output logic [IDX_W-1:0]  result_idx,
  output logic [DATA_W-1:0] result_data,
  output logic [NUM_CH-1:0] above,
  output logic              frame_done,
  output logic              busy,
  output logic              error,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_NEXT  = 3'd4
  } state_t;

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int SMP_W = AVG_LOG2 + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [SMP_W-1:0] SMP_LAST  = SMP_W'((1 << AVG_LOG2) - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);
  localparam logic [CH_W-1:0]  CH_BASE_V = CH_W'(CH_BASE);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [SMP_W-1:0]  smp_q, smp_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              error_q, error_d;
  logic [NUM_CH-1:0] above_q, above_d;
  logic [IDX_W-1:0]  res_idx_q, res_idx_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;

  logic [CH_W-1:0]   cur_ch;
  logic [ACC_W-1:0]  acc_sum;
  logic [TMO_W-1:0]  tmo_inc;
  logic              rsp_hit;
  logic              rsp_miss;
  logic              tmo_hit;
  logic              last_smp;

  // Command handshake: a command transfers on any cycle with cmd_valid && cmd_ready;
  // cmd_valid and cmd_channel stay stable until then and only one command is ever
  // outstanding. Responses carry no ready and are only looked at while in WAIT.
  assign cur_ch   = CH_BASE_V + CH_W'(idx_q);
  assign acc_sum  = acc_q + ACC_W'(rsp_data);
  assign rsp_hit  = rsp_valid && (rsp_channel == cur_ch);
  assign rsp_miss = rsp_valid && (rsp_channel != cur_ch);
  assign tmo_inc  = tmo_q + 1'b1;
  assign tmo_hit  = (tmo_inc == TMO_LIMIT);
  assign last_smp = (smp_q == SMP_LAST);

  always_ff @(posedge SYS_CLK or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_ISSUE;
      ST_ISSUE: if (cmd_ready) state_d = ST_WAIT;
      ST_WAIT: begin
        // A response landing on the timeout cycle still counts.
        if (rsp_hit) begin
          state_d = last_smp ? ST_EMIT : ST_ISSUE;
        end else if (rsp_miss) begin
          state_d = ST_ISSUE;
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT:  state_d = ST_NEXT;
      ST_NEXT: begin
        if ((idx_q != IDX_LAST) || continuous) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d      = idx_q;
    acc_d      = acc_q;
    smp_d      = smp_q;
    tmo_d      = tmo_q;
    error_d    = error_q;
    above_d    = above_q;
    res_idx_d  = res_idx_q;
    res_data_d = res_data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          idx_d   = '0;
          acc_d   = '0;
          smp_d   = '0;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) tmo_d = '0;
      end
      ST_WAIT: begin
        if (rsp_hit) begin
          acc_d = acc_sum;
          if (last_smp) begin
            // Result is latched here so it is already stable during EMIT.
            res_idx_d  = idx_q;
            res_data_d = DATA_W'(acc_sum >> AVG_LOG2);
          end else begin
            smp_d = smp_q + 1'b1;
          end
        end else if (rsp_miss || tmo_hit) begin
          error_d = 1'b1;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      ST_EMIT: begin
        above_d[idx_q] = (res_data_q >= threshold);
      end
      ST_NEXT: begin
        acc_d = '0;
        smp_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge SYS_CLK or posedge reset) begin
    if (reset) begin
      idx_q      <= '0;
      acc_q      <= '0;
      smp_q      <= '0;
      tmo_q      <= '0;
      error_q    <= 1'b0;
      above_q    <= '0;
      res_idx_q  <= '0;
      res_data_q <= '0;
    end else begin
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      smp_q      <= smp_d;
      tmo_q      <= tmo_d;
      error_q    <= error_d;
      above_q    <= above_d;
      res_idx_q  <= res_idx_d;
      res_data_q <= res_data_d;
    end
  end

  always_comb begin
    cmd_valid    = (state_q == ST_ISSUE);
    cmd_sop      = (state_q == ST_ISSUE);
    cmd_eop      = (state_q == ST_ISSUE);
    cmd_channel  = cur_ch;
    result_valid = (state_q == ST_EMIT);
    result_idx   = res_idx_q;
    result_data  = res_data_q;
    frame_done   = (state_q == ST_NEXT) && (idx_q == IDX_LAST);
    busy         = (state_q != ST_IDLE);
    error        = error_q;
    above        = above_q;
    state_dbg    = state_q;
  end

endmodule
